truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 133 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - truth-table sweeper streaming every input vector with its outputs; optional Gray order via SWEEP_GRAY_EN
module truth_table_sweeper #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 1,
   parameter int SIG_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_OUT*(2**N_IN)-1:0]  tt,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_IN-1:0]             out_x,
   output logic [N_OUT-1:0]            out_f,
   output logic                        done,
   output logic [SIG_W-1:0]            sig,
   output logic [N_OUT*(N_IN+1)-1:0]   ones
);

   localparam int TT_N = 1 << N_IN;
   localparam int TT_W = N_OUT * TT_N;
   localparam int CW   = N_IN + 1;
   localparam logic [CW-1:0] LAST = CW'(TT_N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [TT_W-1:0]          tt_q;
   logic [CW-1:0]            cnt;
   logic [CW-1:0]            cnt_inc;
   logic                     xfer;
   logic                     last_beat;
   logic [SIG_W-1:0]         sig_nxt;
   logic [N_OUT*CW-1:0]      ones_nxt;

   // Sweep order: Gray when enabled, otherwise plain binary count.
   function automatic logic [N_IN-1:0] vec(input logic [CW-1:0] c);
`ifdef SWEEP_GRAY_EN
      return c[N_IN-1:0] ^ (c[N_IN-1:0] >> 1);
`else
      return c[N_IN-1:0];
`endif
   endfunction

   // Output bit o for vector v sits in row o of the table.
   function automatic logic [N_OUT-1:0] lookup(input logic [TT_W-1:0] t,
                                               input logic [N_IN-1:0] v);
      logic [N_OUT-1:0] r;
      logic [TT_N-1:0]  row;
      r = '0;
      for (int o = 0; o < N_OUT; o++) begin
         row  = t[o*TT_N +: TT_N];
         r[o] = row[v];
      end
      return r;
   endfunction

   assign xfer      = out_valid && out_ready;
   assign last_beat = (cnt == LAST);
   assign cnt_inc   = cnt + CW'(1);

   // Next-state and status decode; status flags follow the state directly.
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (xfer && last_beat) state_d = S_DONE;
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Signature and ones counters as they will be after the current beat transfers.
   always_comb begin
      sig_nxt  = {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(out_f);
      ones_nxt = ones;
      for (int o = 0; o < N_OUT; o++) begin
         ones_nxt[o*CW +: CW] = ones[o*CW +: CW] + CW'(out_f[o]);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Datapath: latch table on start, advance beat registers on each transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         tt_q  <= '0;
         cnt   <= '0;
         out_x <= '0;
         out_f <= '0;
         sig   <= '0;
         ones  <= '0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            tt_q  <= tt;
            cnt   <= '0;
            sig   <= '0;
            ones  <= '0;
            out_x <= vec('0);
            out_f <= lookup(tt, vec('0));
         end
      end else if (state_q == S_RUN) begin
         if (xfer) begin
            sig  <= sig_nxt;
            ones <= ones_nxt;
            if (!last_beat) begin
               cnt   <= cnt_inc;
               out_x <= vec(cnt_inc);
               out_f <= lookup(tt_q, vec(cnt_inc));
            end
         end
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] tt;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_x;
   logic [0:0]  out_f;
   logic        done;
   logic [15:0] sig;
   logic [4:0]  ones;

   int n_chk = 0;
   int n_err = 0;

   truth_table_sweeper #(.N_IN(4), .N_OUT(1), .SIG_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .tt        (tt),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_f     (out_f),
      .done      (done),
      .sig       (sig),
      .ones      (ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_vec(input int k);
`ifdef SWEEP_GRAY_EN
      return 4'(k ^ (k >> 1));
`else
      return 4'(k);
`endif
   endfunction

   task automatic sweep(input logic [15:0] t, input logic [15:0] exp_sig, input logic [4:0] exp_ones,
                        input int stall_x, input int stall_len, input bit poke);
      int          beats;
      int          stalled;
      int          done_cyc;
      logic [15:0] tv;
      logic [3:0]  sx;
      beats    = 0;
      stalled  = 0;
      done_cyc = -1;
      tv       = t;
      sx       = 4'(stall_x);
      @(negedge clk);
      tt        = t;
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("first_valid", out_valid, 1);
      check("busy_run", busy, 1);
      for (int cyc = 1; cyc < 200; cyc++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (poke && cyc == 3) begin
            tt    = ~t;
            start = 1'b1;
         end else if (poke && cyc == 4) begin
            start = 1'b0;
         end
         out_ready = 1'b1;
         if (stall_x >= 0 && out_valid && out_x == sx && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
         end
         if (out_valid) begin
            check("beat_x", out_x, exp_vec(beats));
            check("beat_f", out_f, tv[exp_vec(beats)]);
            if (out_ready) beats++;
         end else begin
            check("valid_gap", out_valid, 1);
         end
         @(negedge clk);
      end
      check("done_seen", done, 1);
      check("done_cyc", done_cyc, 17 + stall_len);
      check("beats", beats, 16);
      check("done_busy", busy, 1);
      check("done_valid", out_valid, 0);
      check("sig", sig, exp_sig);
      check("ones", ones, exp_ones);
      if (poke) start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b1;
      check("done_len", done, 0);
      check("busy_idle", busy, 0);
      check("sig_hold", sig, exp_sig);
      check("ones_hold", ones, exp_ones);
   endtask

   initial begin
      int beats;
      rst       = 1'b1;
      start     = 1'b0;
      tt        = 16'h0000;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_x", out_x, 0);
      check("rst_f", out_f, 0);
      check("rst_sig", sig, 0);
      check("rst_ones", ones, 0);
      rst = 1'b0;

      sweep(16'hFFFF, 16'hFFFF, 5'd16, -1, 0, 1'b0);
      sweep(16'h0001, 16'h8000, 5'd1, -1, 0, 1'b0);
      sweep(16'h0000, 16'h0000, 5'd0, -1, 0, 1'b0);
`ifdef SWEEP_GRAY_EN
      sweep(16'h0004, 16'h1000, 5'd1, -1, 0, 1'b0);
      sweep(16'hA5A5, 16'h9669, 5'd8, 5, 3, 1'b0);
`else
      sweep(16'h0004, 16'h2000, 5'd1, -1, 0, 1'b0);
      sweep(16'hA5A5, 16'hA5A5, 5'd8, 5, 3, 1'b0);
`endif

      // abort mid-sweep with reset
      @(negedge clk);
      tt    = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      beats = 0;
      for (int c = 0; c < 40; c++) begin
         if (beats == 7) break;
         if (out_valid && out_ready) beats++;
         @(negedge clk);
      end
      check("abort_beat", out_x, exp_vec(7));
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_valid", out_valid, 0);
      check("abort_done", done, 0);
      check("abort_x", out_x, 0);
      check("abort_f", out_f, 0);
      check("abort_sig", sig, 0);
      check("abort_ones", ones, 0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_nodone", done, 0);
      sweep(16'hFFFF, 16'hFFFF, 5'd16, -1, 0, 1'b0);

      // start while busy and at done must be ignored; table stays latched
      sweep(16'h0001, 16'h8000, 5'd1, -1, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
